// File: rtl/xm23_pkg.sv
// xm23_pkg: shared types and helpers for the XM23 memory controller.
//   xm23_state_e : controller state encoding (StIdle / StAccess / StDone)
//   WaitCntW     : width of the wait-state counter (covers 0..7)
//   lane_idx_w() : number of address bits that select a byte lane
package xm23_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } xm23_state_e;

  localparam int unsigned WaitCntW = 3;

  // log2 of the byte-lane count; 1 for a 16-bit bus, 2 for a 32-bit bus.
  function automatic int unsigned lane_idx_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/xm23_byte_lane.sv
// xm23_byte_lane: combinational byte-lane steering for the memory bus.
//   i_byte_acc  : 1 = byte access on lane i_lane, 0 = full-word access
//   i_lane      : byte lane index (low address bits of MAR)
//   i_wdata     : write data held by the controller
//   i_mem_rdata : raw read data from memory
//   o_be        : byte enables (one-hot for bytes, all ones for words)
//   o_wdata     : write data with the low byte replicated to every lane for bytes
//   o_rdata     : read data, selected lane zero-extended for bytes
module xm23_byte_lane
  import xm23_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = DATA_W / 8,
  parameter int unsigned LANE_W = lane_idx_w(DATA_W)
) (
  input  logic              i_byte_acc,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [LANES-1:0]  o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    if (i_byte_acc) begin
      o_be[i_lane] = 1'b1;
      for (int k = 0; k < int'(LANES); k++) begin
        o_wdata[k*8 +: 8] = i_wdata[7:0];
      end
      o_rdata[7:0] = i_mem_rdata[{i_lane, 3'b000} +: 8];
    end else begin
      o_be    = '1;
      o_wdata = i_wdata;
      o_rdata = i_mem_rdata;
    end
  end

endmodule

// File: rtl/xm23_mem_ctrl.sv
// xm23_mem_ctrl: single-outstanding CPU-to-memory access controller.
// Latches a request into MAR / write buffer, drives the memory bus for
// WAIT_STATES+1 cycles, captures read data into MDR and pulses ready.
// Misaligned word requests skip the bus and complete with err=1.
// Optional feature: define XM23_MEM_BKPT_EN to enable the read breakpoint.
// Ports:
//   Clock, Reset_n                 : clock, async active-low reset
//   req, we, byte_acc, addr, wdata : CPU request
//   rdata, ready, err, busy        : CPU response / status
//   mem_addr, mem_en, mem_we, mem_be, mem_wdata, mem_rdata : memory bus
//   bkpt_addr, bkpt_on, bkpt_hit   : read breakpoint
module xm23_mem_ctrl
  import xm23_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                req,
  input  logic                we,
  input  logic                byte_acc,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [ADDR_W-1:0]   bkpt_addr,
  input  logic                bkpt_on,
  output logic                bkpt_hit
);

  localparam int unsigned Lanes = DATA_W / 8;
  localparam int unsigned LaneW = lane_idx_w(DATA_W);
  localparam logic [WaitCntW-1:0] LastCnt = WaitCntW'(WAIT_STATES);

  xm23_state_e         r_state, w_state_nxt;
  logic [WaitCntW-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  // Write data is buffered apart from MDR so writes never disturb rdata.
  logic [DATA_W-1:0]   r_wdr;
  logic                r_we;
  logic                r_byte;
  logic                r_err;

  logic                w_accept;
  logic                w_misalign;
  logic                w_last;
  logic                w_capture;
  logic [Lanes-1:0]    w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_lane_rdata;

  assign w_accept   = (r_state == StIdle) && req;
  assign w_misalign = !byte_acc && (addr[LaneW-1:0] != '0);

  // Next-state and wait counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req) begin
          w_state_nxt = w_misalign ? StDone : StAccess;
          w_cnt_nxt   = '0;
        end
      end
      StAccess: begin
        if (r_cnt == LastCnt) begin
          w_last      = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + WaitCntW'(1);
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_capture = (r_state == StAccess) && w_last && !r_we;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mar  <= '0;
      r_wdr  <= '0;
      r_we   <= 1'b0;
      r_byte <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_mar  <= addr;
      r_wdr  <= wdata;
      r_we   <= we;
      r_byte <= byte_acc;
      r_err  <= w_misalign;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mdr <= '0;
    end else if (w_capture) begin
      r_mdr <= w_lane_rdata;
    end
  end

  xm23_byte_lane #(
    .DATA_W (DATA_W),
    .LANES  (Lanes),
    .LANE_W (LaneW)
  ) u_byte_lane (
    .i_byte_acc  (r_byte),
    .i_lane      (r_mar[LaneW-1:0]),
    .i_wdata     (r_wdr),
    .i_mem_rdata (mem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata     (w_lane_rdata)
  );

  assign mem_en    = (r_state == StAccess);
  assign mem_we    = mem_en && r_we;
  assign mem_be    = mem_en ? w_be : '0;
  assign mem_wdata = w_wdata;
  assign mem_addr  = {r_mar[ADDR_W-1:LaneW], {LaneW{1'b0}}};
  assign ready     = (r_state == StDone);
  assign err       = ready && r_err;
  assign busy      = (r_state != StIdle);
  assign rdata     = r_mdr;

`ifdef XM23_MEM_BKPT_EN
  logic r_bkpt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bkpt <= 1'b0;
    end else if (w_accept) begin
      r_bkpt <= !we && bkpt_on && (addr == bkpt_addr);
    end
  end

  assign bkpt_hit = ready && r_bkpt;
`else
  logic w_unused_bkpt;
  assign w_unused_bkpt = ^{bkpt_addr, bkpt_on};
  assign bkpt_hit      = 1'b0;
`endif

endmodule

// File: tb/tb_xm23_mem_ctrl.sv
// tb_xm23_mem_ctrl: directed self-checking bench. Three controllers share the
// CPU-side stimulus: 16-bit/1 wait state, 16-bit/3 wait states, 32-bit/1 wait
// state. Observations are taken 1 time unit after each rising edge; index k=0
// is the sample right after the accepting edge.
module tb_xm23_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req, we, byte_acc, bkpt_on;
  logic [15:0] addr, bkpt_addr;
  logic [31:0] wdata, mem_rdata;

  logic [15:0] rdata16, maddr16, mwd16;
  logic        ready16, err16, busy16, en16, we16, hit16;
  logic [1:0]  be16;

  logic [15:0] rdata3, maddr3, mwd3;
  logic        ready3, err3, busy3, en3, we3, hit3;
  logic [1:0]  be3;

  logic [31:0] rdata32, mwd32;
  logic [15:0] maddr32;
  logic        ready32, err32, busy32, en32, we32, hit32;
  logic [3:0]  be32;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-access observations
  int          en_cnt16, we_cnt16, rdy_k16, en_cnt3, rdy_k3, rdy_k32, rdy_n3;
  logic [31:0] be16_s, mwd16_s, maddr16_s, err16_s, hit16_s, be32_s, maddr32_s;

`ifdef XM23_MEM_BKPT_EN
  localparam logic ExpHit = 1'b1;
`else
  localparam logic ExpHit = 1'b0;
`endif

  xm23_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) u_dut16 (
    .Clock(clk), .Reset_n(rst_n), .req(req), .we(we), .byte_acc(byte_acc),
    .addr(addr), .wdata(wdata[15:0]), .rdata(rdata16), .ready(ready16), .err(err16),
    .busy(busy16), .mem_addr(maddr16), .mem_en(en16), .mem_we(we16), .mem_be(be16),
    .mem_wdata(mwd16), .mem_rdata(mem_rdata[15:0]), .bkpt_addr(bkpt_addr),
    .bkpt_on(bkpt_on), .bkpt_hit(hit16)
  );

  xm23_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(3)) u_dut_ws3 (
    .Clock(clk), .Reset_n(rst_n), .req(req), .we(we), .byte_acc(byte_acc),
    .addr(addr), .wdata(wdata[15:0]), .rdata(rdata3), .ready(ready3), .err(err3),
    .busy(busy3), .mem_addr(maddr3), .mem_en(en3), .mem_we(we3), .mem_be(be3),
    .mem_wdata(mwd3), .mem_rdata(mem_rdata[15:0]), .bkpt_addr(bkpt_addr),
    .bkpt_on(bkpt_on), .bkpt_hit(hit3)
  );

  xm23_mem_ctrl #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(1)) u_dut32 (
    .Clock(clk), .Reset_n(rst_n), .req(req), .we(we), .byte_acc(byte_acc),
    .addr(addr), .wdata(wdata), .rdata(rdata32), .ready(ready32), .err(err32),
    .busy(busy32), .mem_addr(maddr32), .mem_en(en32), .mem_we(we32), .mem_be(be32),
    .mem_wdata(mwd32), .mem_rdata(mem_rdata), .bkpt_addr(bkpt_addr),
    .bkpt_on(bkpt_on), .bkpt_hit(hit32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; req stays high for 'hold' accepting/ignored edges.
  task automatic run_access(input logic w, input logic b, input logic [15:0] a,
                            input logic [31:0] d, input int hold);
    we = w; byte_acc = b; addr = a; wdata = d; req = 1'b1;
    en_cnt16 = 0; we_cnt16 = 0; rdy_k16 = -1; en_cnt3 = 0; rdy_k3 = -1; rdy_k32 = -1;
    be16_s = '0; mwd16_s = '0; maddr16_s = '0; err16_s = '0; hit16_s = '0;
    be32_s = '0; maddr32_s = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k + 1 >= hold) req = 1'b0;
      if (en16) begin
        en_cnt16++; be16_s = 32'(be16); mwd16_s = 32'(mwd16); maddr16_s = 32'(maddr16);
      end
      if (we16) we_cnt16++;
      if (ready16 && rdy_k16 < 0) begin
        rdy_k16 = k; err16_s = 32'(err16); hit16_s = 32'(hit16);
      end
      if (en3) en_cnt3++;
      if (ready3 && rdy_k3 < 0) rdy_k3 = k;
      if (en32) begin be32_s = 32'(be32); maddr32_s = 32'(maddr32); end
      if (ready32 && rdy_k32 < 0) rdy_k32 = k;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; byte_acc = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; bkpt_addr = '0; bkpt_on = 1'b0;
    #12;
    check_val("rst_rdata", 32'(rdata16), 32'h0);
    check_val("rst_mem_addr", 32'(maddr16), 32'h0);
    check_val("rst_outs", {26'd0, busy16, ready16, err16, en16, we16, hit16}, 32'h0);
    check_val("rst_be", 32'(be16), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word read, 0x0010 -> 0xBEEF
    mem_rdata = 32'h0000_BEEF;
    run_access(1'b0, 1'b0, 16'h0010, 32'h0, 1);
    check_val("rd_ready_k", 32'(rdy_k16), 32'd2);
    check_val("rd_en_cycles", 32'(en_cnt16), 32'd2);
    check_val("rd_we_cycles", 32'(we_cnt16), 32'd0);
    check_val("rd_rdata", 32'(rdata16), 32'h0000_BEEF);
    check_val("rd_err", err16_s, 32'h0);
    check_val("rd_mem_addr", maddr16_s, 32'h0010);
    check_val("rd_be_word", be16_s, 32'h3);
    check_val("ws3_ready_k", 32'(rdy_k3), 32'd4);
    check_val("ws3_en_cycles", 32'(en_cnt3), 32'd4);
    check_val("ws3_rdata", 32'(rdata3), 32'h0000_BEEF);

    // Byte write 0x0021, 0xA5 on lane 1
    mem_rdata = 32'h0000_1111;
    run_access(1'b1, 1'b1, 16'h0021, 32'h0000_00A5, 1);
    check_val("bw_be", be16_s, 32'h2);
    check_val("bw_wdata", mwd16_s, 32'h0000_A5A5);
    check_val("bw_we_cycles", 32'(we_cnt16), 32'd2);
    check_val("bw_mem_addr", maddr16_s, 32'h0020);
    check_val("bw_rdata_kept", 32'(rdata16), 32'h0000_BEEF);

    // Misaligned word read 0x0003
    run_access(1'b0, 1'b0, 16'h0003, 32'h0, 1);
    check_val("mis_en_cycles", 32'(en_cnt16), 32'd0);
    check_val("mis_ready_k", 32'(rdy_k16), 32'd0);
    check_val("mis_err", err16_s, 32'h1);
    check_val("mis_rdata_kept", 32'(rdata16), 32'h0000_BEEF);

    // Byte reads on both 16-bit lanes
    mem_rdata = 32'h1122_5A3C;
    run_access(1'b0, 1'b1, 16'h0031, 32'h0, 1);
    check_val("br_hi_rdata", 32'(rdata16), 32'h0000_005A);
    check_val("br_hi_be", be16_s, 32'h2);
    run_access(1'b0, 1'b1, 16'h0030, 32'h0, 1);
    check_val("br_lo_rdata", 32'(rdata16), 32'h0000_003C);
    check_val("br_lo_be", be16_s, 32'h1);

    // 32-bit byte read 0x0006 -> lane 2
    mem_rdata = 32'h1122_3344;
    run_access(1'b0, 1'b1, 16'h0006, 32'h0, 1);
    check_val("b32_rdata", rdata32, 32'h0000_0022);
    check_val("b32_be", be32_s, 32'h4);
    check_val("b32_mem_addr", maddr32_s, 32'h0004);
    check_val("b32_ready_k", 32'(rdy_k32), 32'd2);
    check_val("b16_rdata", 32'(rdata16), 32'h0000_0044);

    // req held over a busy edge must not start a second access
    mem_rdata = 32'h0000_1234;
    run_access(1'b0, 1'b0, 16'h0040, 32'h0, 2);
    check_val("busy_en_cycles", 32'(en_cnt16), 32'd2);
    check_val("busy_mem_addr", maddr16_s, 32'h0040);
    check_val("busy_rdata", 32'(rdata16), 32'h0000_1234);

    // Breakpoint
    bkpt_on = 1'b1; bkpt_addr = 16'h00F6;
    run_access(1'b0, 1'b0, 16'h00F6, 32'h0, 1);
    check_val("bkpt_hit_match", hit16_s, 32'(ExpHit));
    check_val("bkpt_ready_k", 32'(rdy_k16), 32'd2);
    run_access(1'b0, 1'b0, 16'h00F8, 32'h0, 1);
    check_val("bkpt_hit_other", hit16_s, 32'h0);
    bkpt_on = 1'b0;

    // Reset in the 2nd ACCESS cycle of the 3-wait-state controller
    mem_rdata = 32'h0000_CAFE;
    we = 1'b0; byte_acc = 1'b0; addr = 16'h0010; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    check_val("rst_mid_en_before", 32'(en3), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_en_async", 32'(en3), 32'h0);
    check_val("rst_mid_busy", 32'(busy3), 32'h0);
    #2; rst_n = 1'b1;
    rdy_n3 = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ready3) rdy_n3++;
    end
    check_val("rst_mid_no_ready", 32'(rdy_n3), 32'd0);
    check_val("rst_mid_rdata", 32'(rdata3), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
